// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue_if
// Description : Bus bundle for the instruction fetch front end. It carries
//               the instruction ROM read port, the issue-stage valid/ready
//               handshake, the branch redirect request and the halt status.
//               master = fetch queue side, slave = ROM / issue / branch side.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_queue_if;

  // Instruction ROM read port
  logic        rom_nrd;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  // Issue-stage handshake
  logic        issue_valid;
  logic [31:0] issue_instr;
  logic [31:0] issue_pc;
  logic        issue_ready;

  // Control flow and status
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

  modport master (
    output rom_nrd,
    output rom_addr,
    input  rom_data,
    output issue_valid,
    output issue_instr,
    output issue_pc,
    input  issue_ready,
    input  redirect,
    input  redirect_pc,
    output halted
  );

  modport slave (
    input  rom_nrd,
    input  rom_addr,
    output rom_data,
    input  issue_valid,
    input  issue_instr,
    input  issue_pc,
    output issue_ready,
    output redirect,
    output redirect_pc,
    input  halted
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Instruction fetch front end. Reads 32-bit words from the
//               instruction ROM, buffers {instr, pc} pairs in a DEPTH-entry
//               FIFO and presents them to issue over valid/ready. Supports
//               branch redirect with full flush and stops fetching on a halt
//               opcode (bits [31:26] all ones) or at the end of ROM.
//               Optional macro IFQ_BYPASS_EN: an empty queue forwards the
//               word being fetched straight to the issue outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_BYTES = 100
) (
  input  logic               clk,
  input  logic               nrst,
  instr_fetch_queue_if.master bus
);

  localparam int              PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW          = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   C_DEPTH     = CW'(DEPTH);
  localparam logic [32:0]     C_ROM_BYTES = 33'(ROM_BYTES);
  localparam logic [5:0]      C_HALT_OP   = 6'b111111;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_next;

  logic [31:0]    r_pc;
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [31:0]    r_instr_mem [DEPTH];
  logic [31:0]    r_pc_mem    [DEPTH];

  logic           w_pc_in_rom;
  logic           w_fetch;
  logic           w_is_halt;
  logic           w_head_valid;
  logic           w_push;
  logic           w_pop;
  logic           w_unused_redirect_lsbs;

  // The low address bits of the redirect target are discarded on purpose.
  assign w_unused_redirect_lsbs = &{1'b0, bus.redirect_pc[1:0]};

  // 33-bit compare so a PC near the top of the address space cannot wrap
  // into a false "in ROM" result.
  assign w_pc_in_rom  = ({1'b0, r_pc} + 33'd3) < C_ROM_BYTES;

  // Fetch is decoded from registered state and redirect only; the strobe is
  // also held inactive while reset is asserted.
  assign w_fetch      = nrst && (r_state == ST_RUN) && (r_count < C_DEPTH)
                        && w_pc_in_rom && !bus.redirect;
  assign w_is_halt    = (bus.rom_data[31:26] == C_HALT_OP);
  assign w_head_valid = (r_count != '0);

  assign bus.rom_nrd  = ~w_fetch;
  assign bus.rom_addr = r_pc;
  assign bus.halted   = (r_state == ST_HALTED);

`ifdef IFQ_BYPASS_EN
  logic w_bypass;

  // An empty queue lets the word being fetched appear on issue this cycle.
  assign w_bypass        = w_fetch && !w_head_valid;
  assign bus.issue_valid = w_head_valid || w_bypass;
  assign bus.issue_instr = w_head_valid ? r_instr_mem[r_rd_ptr] :
                           (w_bypass ? bus.rom_data : 32'h0);
  assign bus.issue_pc    = w_head_valid ? r_pc_mem[r_rd_ptr] :
                           (w_bypass ? r_pc : 32'h0);
  // A bypassed word accepted by issue never enters the queue.
  assign w_push          = w_fetch && !(w_bypass && bus.issue_ready);
  assign w_pop           = w_head_valid && bus.issue_ready && !bus.redirect;
`else
  // Issue outputs come from queue registers only.
  assign bus.issue_valid = w_head_valid;
  assign bus.issue_instr = w_head_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
  assign bus.issue_pc    = w_head_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
  assign w_push          = w_fetch;
  assign w_pop           = w_head_valid && bus.issue_ready && !bus.redirect;
`endif

  // Fetch state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: redirect restarts fetch; halt opcode or end of ROM stops it.
  always_comb begin
    w_state_next = r_state;
    if (bus.redirect) begin
      w_state_next = ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (w_fetch && w_is_halt) begin
        w_state_next = ST_HALTED;
      end else if (!w_pc_in_rom) begin
        w_state_next = ST_HALTED;
      end
    end
  end

  // Program counter: redirect target (word aligned) or advance per fetch.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_pc <= {bus.redirect_pc[31:2], 2'b00};
    end else if (w_fetch) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Queue pointers and occupancy; redirect flushes and discards push/pop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= bus.rom_data;
      r_pc_mem[r_wr_ptr]    <= r_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue. Directed stimulus
//               pushes expected {instr, pc} pairs into a scoreboard; a monitor
//               pops and compares on every accepted issue beat. Direct checks
//               cover ROM strobe/address timing, halt, redirect and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

  logic        clk;
  logic        nrst;
  logic [31:0] rom_mem [0:31];
  logic [63:0] sb [$];
  int          n_checks;
  int          n_fail;

  instr_fetch_queue_if bus ();

  instr_fetch_queue #(
    .DEPTH     (4),
    .RESET_PC  (32'h0000_0000),
    .ROM_BYTES (100)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.master)
  );

  // Combinational ROM model.
  assign bus.rom_data = (bus.rom_addr < 32'd100) ? rom_mem[bus.rom_addr[6:2]] : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hand-written ROM contents used from test 2 on.
  function automatic logic [31:0] exp_word(input int k);
    case (k)
      0:       return 32'h2001_0005;
      1:       return 32'h2002_0003;
      2:       return 32'h2003_0007;
      default: return 32'h0100_0000 + 32'(k);
    endcase
  endfunction

  // Scoreboard monitor: compare every accepted issue beat.
  always @(negedge clk) begin
    if (nrst && bus.issue_valid && bus.issue_ready && !bus.redirect) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h expected no issue", bus.issue_pc);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("sb_instr", bus.issue_instr, e[63:32]);
        chk("sb_pc",    bus.issue_pc,    e[31:0]);
      end
    end
  end

  // Redirect in the current cycle; returns one cycle later with redirect low.
  task automatic redirect_to(input logic [31:0] target);
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    #1;
    chk("redir_nrd", 32'(bus.rom_nrd), 32'd1);
    step();
    bus.redirect = 1'b0;
    #1;
  endtask

  // Stream with ready high until end of ROM, then drain the queue.
  task automatic run_to_end(input string tag);
    logic [31:0] last;
    last = 32'hFFFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      if (bus.rom_addr == 32'd100) break;
      if (!bus.rom_nrd) last = bus.rom_addr;
      step();
    end
    chk({tag, "_last_fetch"}, last, 32'd96);
    chk({tag, "_end_addr"},   bus.rom_addr, 32'd100);
    chk({tag, "_end_nrd"},    32'(bus.rom_nrd), 32'd1);
    chk({tag, "_end_halt0"},  32'(bus.halted), 32'd0);
    step();
    chk({tag, "_end_halt1"},  32'(bus.halted), 32'd1);
    chk({tag, "_end_nrd1"},   32'(bus.rom_nrd), 32'd1);
    repeat (6) step();
    chk({tag, "_sb_empty"},   32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    nrst            = 1'b0;
    bus.issue_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    for (int k = 0; k < 32; k++) rom_mem[k] = 32'h0100_0000 + 32'(k);
    rom_mem[0] = 32'h2001_0005;
    rom_mem[1] = 32'h2002_0003;
    rom_mem[2] = 32'hFC00_0000;

    // Reset values
    repeat (3) step();
    chk("rst_nrd",    32'(bus.rom_nrd),     32'd1);
    chk("rst_addr",   bus.rom_addr,         32'h0);
    chk("rst_valid",  32'(bus.issue_valid), 32'd0);
    chk("rst_instr",  bus.issue_instr,      32'h0);
    chk("rst_pc",     bus.issue_pc,         32'h0);
    chk("rst_halted", 32'(bus.halted),      32'd0);

    // Test 1: three words ending in a halt, issue always ready
    sb.push_back({32'h2001_0005, 32'h0});
    sb.push_back({32'h2002_0003, 32'h4});
    sb.push_back({32'hFC00_0000, 32'h8});
    nrst = 1'b1;
    #1;
    chk("t1_c0_nrd",  32'(bus.rom_nrd), 32'd0);
    chk("t1_c0_addr", bus.rom_addr,     32'h0);
    step();
    chk("t1_c1_addr", bus.rom_addr,     32'h4);
    chk("t1_c1_ipc",  bus.issue_pc,     32'h0);
    step();
    chk("t1_c2_addr", bus.rom_addr,     32'h8);
    chk("t1_c2_ipc",  bus.issue_pc,     32'h4);
    step();
    chk("t1_c3_halt", 32'(bus.halted),  32'd1);
    chk("t1_c3_nrd",  32'(bus.rom_nrd), 32'd1);
    chk("t1_c3_ipc",  bus.issue_pc,     32'h8);
    step();
    chk("t1_c4_valid", 32'(bus.issue_valid), 32'd0);
    chk("t1_c4_nrd",   32'(bus.rom_nrd),     32'd1);
    chk("t1_sb_empty", 32'(sb.size()),       32'd0);

    // Test 2: back-pressure fills the queue, then drain; run to end of ROM
    rom_mem[2]      = 32'h2003_0007;
    bus.issue_ready = 1'b0;
    redirect_to(32'h0);
    chk("t2_halt_clr", 32'(bus.halted), 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      chk("t2_fill_addr", bus.rom_addr,     32'(4 * k));
      chk("t2_fill_nrd",  32'(bus.rom_nrd), 32'd0);
    end
    step();
    chk("t2_full_nrd",  32'(bus.rom_nrd),     32'd1);
    chk("t2_full_addr", bus.rom_addr,         32'h10);
    chk("t2_full_val",  32'(bus.issue_valid), 32'd1);
    chk("t2_full_ipc",  bus.issue_pc,         32'h0);
    step();
    chk("t2_full2_nrd", 32'(bus.rom_nrd), 32'd1);
    for (int k = 0; k < 25; k++) sb.push_back({exp_word(k), 32'(4 * k)});
    bus.issue_ready = 1'b1;
    #1;
    chk("t2_d0_nrd",  32'(bus.rom_nrd), 32'd1);
    step();
    chk("t2_d1_nrd",  32'(bus.rom_nrd), 32'd0);
    chk("t2_d1_addr", bus.rom_addr,     32'h10);
    run_to_end("t2");

    // Test 3: redirect to 0x2A with three entries queued
    bus.issue_ready = 1'b0;
    redirect_to(32'h0);
    chk("t3_restart_halt", 32'(bus.halted),  32'd0);
    chk("t3_restart_nrd",  32'(bus.rom_nrd), 32'd0);
    chk("t3_restart_addr", bus.rom_addr,     32'h0);
    step();
    step();
    step();
    chk("t3_pre_addr",  bus.rom_addr,         32'hC);
    chk("t3_pre_valid", 32'(bus.issue_valid), 32'd1);
    chk("t3_pre_ipc",   bus.issue_pc,         32'h0);
    redirect_to(32'h2A);
    chk("t3_flush_valid", 32'(bus.issue_valid), 32'd0);
    chk("t3_new_addr",    bus.rom_addr,         32'h28);
    chk("t3_new_nrd",     32'(bus.rom_nrd),     32'd0);
    for (int k = 10; k < 25; k++) sb.push_back({exp_word(k), 32'(4 * k)});
    bus.issue_ready = 1'b1;
    step();
    chk("t3_first_valid", 32'(bus.issue_valid), 32'd1);
    chk("t3_first_ipc",   bus.issue_pc,         32'h28);
    chk("t3_first_instr", bus.issue_instr,      32'h0100_000A);
    run_to_end("t3");

    // Test 5: asynchronous reset while the queue is full
    bus.issue_ready = 1'b0;
    redirect_to(32'h40);
    repeat (4) step();
    chk("t5_full_nrd",  32'(bus.rom_nrd),     32'd1);
    chk("t5_full_addr", bus.rom_addr,         32'h50);
    chk("t5_full_ipc",  bus.issue_pc,         32'h40);
    nrst = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.issue_valid), 32'd0);
    chk("t5_rst_nrd",   32'(bus.rom_nrd),     32'd1);
    chk("t5_rst_addr",  bus.rom_addr,         32'h0);
    chk("t5_rst_halt",  32'(bus.halted),      32'd0);
    chk("t5_rst_ipc",   bus.issue_pc,         32'h0);
    step();
    nrst = 1'b1;
    #1;
    chk("t5_rel_nrd",  32'(bus.rom_nrd), 32'd0);
    chk("t5_rel_addr", bus.rom_addr,     32'h0);
    step();
    chk("t5_lat_valid", 32'(bus.issue_valid), 32'd1);
    chk("t5_lat_ipc",   bus.issue_pc,         32'h0);
    chk("t5_lat_instr", bus.issue_instr,      32'h2001_0005);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch front end for the Tomasulo core. It is the initiator side of the instruction ROM read port: it drives the byte address and the active-low read strobe, and it captures the 32-bit big-endian word. Fetched instructions and their PCs are buffered in a small FIFO that feeds the issue stage through a valid/ready handshake. The block supports branch redirect with a full queue flush, and it stops fetching on a halt instruction or at the end of ROM.

## Interface
- `DEPTH`, 4: number of queue entries. Must be a power of 2 and at least 2.
- `RESET_PC`, 0: byte address of the first fetch after reset.
- `ROM_BYTES`, 100: ROM size in bytes. A fetch is legal only when `pc + 3 < ROM_BYTES`.
- `clk`  in  1: clock. All state updates on the rising edge.
- `nrst`  in  1: reset, asynchronous and active-low.
- `rom_nrd`  out  1: ROM read strobe, active-low. 0 means a fetch happens this cycle.
- `rom_addr`  out  32: ROM byte address. Always equal to the PC register.
- `rom_data`  in  32: ROM word, combinational from `rom_addr`. Captured at the edge that ends a fetch cycle.
- `issue_valid`  out  1: the queue head is valid.
- `issue_instr`  out  32: instruction at the queue head. 0 when the queue is empty.
- `issue_pc`  out  32: byte address of the queue head. 0 when the queue is empty.
- `issue_ready`  in  1: issue stage accepts the head this cycle.
- `redirect`  in  1: branch or jump redirect, single-cycle pulse.
- `redirect_pc`  in  32: new fetch address. Bits [1:0] are forced to 0.
- `halted`  out  1: fetch has stopped because of a halt instruction or end of ROM.

## Operation
- States:
  - RUN: fetching.
  - HALTED: not fetching. The queue still drains.
- Fetch condition (`rom_nrd = 0`): state is RUN, `count < DEPTH`, `pc + 3 < ROM_BYTES`, and `redirect` is low. The condition is decoded from registers and `redirect` only. It never depends on `issue_ready`.
- Fetch edge:
  - push `{rom_data, pc}` into the queue;
  - `pc <= pc + 4`.
- Halt detection: the pushed word has `rom_data[31:26] == 6'b111111`.
  - The halt word is enqueued.
  - State goes to HALTED and `halted <= 1`.
- End of ROM: in RUN with `pc + 3 >= ROM_BYTES`, state goes to HALTED and `halted <= 1` on the next edge. Nothing is pushed.
- Pop: `issue_valid && issue_ready` at an edge removes the head.
- Push and pop in the same edge: `count` is unchanged and both pointers advance.
- Full queue: the push is blocked even if a pop happens in the same cycle (registered decision). Throughput when full is therefore 1 instruction per 2 cycles.
- Pointers wrap modulo `DEPTH`. `count` is `$clog2(DEPTH+1)` bits wide.
- Redirect has top priority:
  - flush the queue (`count`, pointers to 0);
  - `pc <= {redirect_pc[31:2], 2'b00}`;
  - state goes to RUN and `halted <= 0`.
  - Any pop or push in that cycle is discarded. The issue stage treats the redirect cycle as a squash.
- PC arithmetic is 32-bit and wraps. `rom_addr` is never driven with a misaligned value.

## Timing
- Reset values:
  - `pc = RESET_PC`, so `rom_addr = RESET_PC`;
  - `rom_nrd = 1` while `nrst` is low;
  - `issue_valid = 0`, `issue_instr = 0`, `issue_pc = 0`;
  - `halted = 0`, state RUN, `count = 0`.
- First fetch: the first cycle after `nrst` deasserts.
- Fetch-to-issue latency: 1 cycle. A word fetched in cycle N is visible on `issue_*` in cycle N+1.
- Redirect latency: the redirect is asserted in cycle N, the first fetch at `redirect_pc` is in N+1, and its `issue_valid` appears in N+2.
- Reset asserted mid-operation: all state clears asynchronously. In-flight entries are lost.
- `issue_*` outputs are driven from the queue registers only, with no combinational path from `rom_data`. This does not hold when `IFQ_BYPASS_EN` is defined.

## Configuration
- `IFQ_BYPASS_EN` defined: when the queue is empty and a fetch occurs in cycle N, `rom_data` and `pc` go straight to `issue_instr`/`issue_pc` and `issue_valid = 1` in cycle N.
  - If `issue_ready = 1`, the word is consumed and not written to the queue.
  - Otherwise it is enqueued normally.
  - Halt detection and the PC update are unchanged.
- `IFQ_BYPASS_EN` undefined: fetch-to-issue latency is always 1 cycle and the issue outputs are purely registered.

## Test plan
- Reset release with ROM words `0x20010005, 0x20020003, 0xFC000000` at addresses 0/4/8 and `issue_ready = 1`:
  - `rom_addr` goes 0, 4, 8;
  - `issue_pc` goes 0, 4, 8 starting one cycle later;
  - after the halt word, `halted = 1` and `rom_nrd` stays 1.
- `issue_ready = 0` with `DEPTH = 4`:
  - exactly 4 fetches (addresses 0–12), then `rom_nrd = 1`;
  - raising `issue_ready` drains in order 0, 4, 8, 12, and fetching resumes at 16.
- Redirect to `0x2A` while the queue holds 3 entries:
  - the queue flushes and `issue_valid = 0` next cycle;
  - `rom_addr = 0x28`;
  - the first issued PC is `0x28`, two cycles after the redirect.
- With `ROM_BYTES = 100`, no halt word, and `issue_ready = 1`:
  - the last fetch is at 96;
  - `halted = 1` one cycle after `pc = 100`;
  - a later redirect to 0 clears `halted` and fetching restarts.
- `nrst` pulsed low while the queue is full: immediately `issue_valid = 0`, `rom_nrd = 1`, and `rom_addr = RESET_PC`.
- With `IFQ_BYPASS_EN`, empty queue, and `issue_ready = 1`: `issue_pc` equals `rom_addr` in the same cycle, and `count` stays 0.
